// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port owner: post-reset clear, then A/B writeback arbitration
// Optional REGFILE_WB_RR_EN selects round-robin arbitration; otherwise A has fixed priority over B.
module regfile_wb_arbiter #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              done_d;
  logic              run;

  // Readies are gated by reset_n so nothing is accepted on an edge that resets the block.
  assign run = reset_n && (state_q == S_RUN);

`ifdef REGFILE_WB_RR_EN
  logic ptr_q, ptr_d;  // 0 = A preferred, 1 = B preferred

  assign a_ready = run & a_valid & (~b_valid | ~ptr_q);
  assign b_ready = run & b_valid & (~a_valid | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (a_ready) begin
      ptr_d = 1'b1;
    end else if (b_ready) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign a_ready = run & a_valid;
  assign b_ready = run & b_valid & ~a_valid;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    done_d  = init_done;
    case (state_q)
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        done_d = 1'b1;
        // x0 is hardwired zero: the handshake completes but no write is issued.
        if (a_ready) begin
          if (a_addr != '0) begin
            we_d    = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
          end
        end else if (b_ready) begin
          if (b_addr != '0) begin
            we_d    = 1'b1;
            waddr_d = b_addr;
            wdata_d = b_data;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_we     <= we_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
      init_done <= done_d;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x64 register file.
- After reset, sequences a clear of every register to zero. Then arbitrates between two writeback requesters: A (ALU result) and B (load/memory result), using valid/ready handshakes.
- Drives the register file's RegWrite/WriteReg/WriteData inputs from registered outputs. Read ports are untouched.

Parameters:
- DATA_W, 64, writeback data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers cleared after reset (must be <= 2**ADDR_W)
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = go straight to RUN

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's request accepted this cycle
- a_addr  in  ADDR_W  A destination register (instruction[11:7])
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B's request accepted this cycle
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- rf_we  out  1  to register file RegWrite
- rf_waddr  out  ADDR_W  to register file WriteReg
- rf_wdata  out  DATA_W  to register file WriteData
- init_done  out  1  clear sequence finished; arbiter live

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (sampled only on the rising edge of clock).
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0.
  - a_ready=0, b_ready=0.
  - State=CLEAR (or RUN if CLEAR_ON_RESET=0); clear counter=0; round-robin pointer=A.
- CLEAR state:
  - On each edge with reset_n=1, register rf_we=1, rf_waddr=cnt, rf_wdata=0, then cnt++.
  - Address 0 is included, giving exactly NUM_REGS consecutive rf_we cycles.
  - a_ready and b_ready are held 0.
  - On the edge that issues address NUM_REGS-1, next state=RUN.
  - On the following edge, init_done=1 and rf_we follows RUN rules.
- CLEAR_ON_RESET=0: the first edge after reset release enters RUN with init_done=1; no clear writes are issued.
- RUN state, ready signals:
  - a_ready and b_ready are combinational from the valids, state and pointer.
  - At most one ready is high per cycle; a ready is never high while its valid is low.
- RUN state, arbitration:
  - Default is fixed priority: a_ready = a_valid; b_ready = b_valid & ~a_valid.
- RUN state, accept and latency:
  - A handshake (valid & ready) completes in that cycle.
  - On the same edge, register rf_we=1, rf_waddr=addr, rf_wdata=data of the winner. Latency is 1 cycle from handshake to rf_we.
  - One write per cycle; back-to-back accepts give back-to-back rf_we.
- No handshake: rf_we=0; rf_waddr and rf_wdata hold their last values.
- Address 0 writes: the handshake completes (ready=1) but rf_we=0. x0 stays zero.
- Requester contract: valid, addr and data are held stable until ready. The arbiter never drops an accepted request.
- Reset mid-operation:
  - reset_n low at any edge restores all reset values, including mid-CLEAR (the counter restarts at 0).
  - Any in-flight registered write is cancelled (rf_we=0).
- Simultaneous A and B to the same register: the winner writes first and the loser writes on a later cycle. The last accepted write wins.

Optional Feature:
- Macro: REGFILE_WB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester; the reset value is A.
  - When both valids are high, the preferred one is granted and the pointer flips to the other.
  - A single requester is granted regardless of the pointer, and the pointer is set to the other requester.
  - Guarantees B waits at most 1 grant while A streams.
- Undefined: fixed priority A over B as above; no pointer flop exists.

Test Plan:
- Reset clear: hold reset_n=0 for 3 cycles, release with no valids. Expect rf_we=1 for exactly 32 cycles with rf_waddr 0..31 and rf_wdata=0. init_done rises on cycle 33 and a_ready/b_ready stay 0 throughout.
- Single writes: after init_done, a_valid with a_addr=5, a_data=0xDEADBEEF_00000001. Expect a_ready=1 the same cycle, then next cycle rf_we=1, rf_waddr=5, rf_wdata=that value. Repeat on B with addr 31.
- Contention, fixed priority: a_valid and b_valid held high for 4 cycles (A addr 1, B addr 2). Expect 4 A grants and b_ready=0. B is granted on the cycle A drops.
- Contention with REGFILE_WB_RR_EN: the same stimulus gives grants alternating A, B, A, B and rf_waddr sequence 1, 2, 1, 2.
- x0 write: a_valid, a_addr=0, a_data=0xFFFF. Expect a_ready=1 and rf_we=0 on the next cycle.
- Reset mid-clear: drop reset_n at clear count 10 for 1 cycle. Expect rf_we=0 that cycle, then the clear restarts at address 0 and runs 32 writes before init_done=1.
